// File: rtl/xgmii_port_fanout.sv
// XGMII fan-out/select: one app TX stream to NPORTS ports, one port RX stream to the app.
// Mask/select changes land only on frame boundaries. `XGMII_FANOUT_CNT_EN adds per-port TX start counters.

module xgmii_frame_trk (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] d,
  input  logic [7:0]  c,
  output logic        start,
  output logic        bnd
);
  logic in_frame, in_frame_nxt;

  // Lanes are scanned in ascending order so the later marker in a word wins.
  always_comb begin
    start        = (c[0] && d[7:0] == 8'hFB) || (c[4] && d[39:32] == 8'hFB);
    in_frame_nxt = in_frame;
    for (int k = 0; k < 8; k++) begin
      if (c[k] && d[8*k +: 8] == 8'hFD) in_frame_nxt = 1'b0;
      if ((k == 0 || k == 4) && c[k] && d[8*k +: 8] == 8'hFB) in_frame_nxt = 1'b1;
    end
    bnd = !in_frame && !start;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) in_frame <= 1'b0;
    else     in_frame <= in_frame_nxt;
endmodule

module xgmii_tx_lane (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] app_txd,
  input  logic [7:0]  app_txc,
  input  logic        app_start,
  input  logic        tx_bnd,
  input  logic        mask_en,
  input  logic        link_up,
  output logic [63:0] txd,
  output logic [7:0]  txc,
  output logic [31:0] frame_cnt
);
  logic resume, drive;

  // After a link loss the port waits for an app boundary so it never starts mid-frame.
  assign drive = mask_en && link_up && (resume || tx_bnd);

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      resume <= 1'b1;
      txd    <= 64'h0707070707070707;
      txc    <= 8'hFF;
    end else begin
      resume <= link_up && (resume || tx_bnd);
      txd    <= drive ? app_txd : 64'h0707070707070707;
      txc    <= drive ? app_txc : 8'hFF;
    end

`ifdef XGMII_FANOUT_CNT_EN
  always_ff @(posedge clk or posedge rst)
    if (rst)                    frame_cnt <= '0;
    else if (drive && app_start) frame_cnt <= frame_cnt + 32'd1;
`else
  logic unused_start;
  assign unused_start = app_start;
  assign frame_cnt    = '0;
`endif
endmodule

module xgmii_port_fanout #(
  parameter int                NPORTS       = 4,
  parameter int                SELW         = (NPORTS > 1) ? $clog2(NPORTS) : 1,
  parameter logic [NPORTS-1:0] TX_MASK_INIT = {NPORTS{1'b1}}
) (
  input  logic                 xgmii_clk,
  input  logic                 sys_rst,
  input  logic [63:0]          app_txd,
  input  logic [7:0]           app_txc,
  output logic [63:0]          app_rxd,
  output logic [7:0]           app_rxc,
  output logic [64*NPORTS-1:0] port_txd,
  output logic [8*NPORTS-1:0]  port_txc,
  input  logic [64*NPORTS-1:0] port_rxd,
  input  logic [8*NPORTS-1:0]  port_rxc,
  input  logic [NPORTS-1:0]    link_up,
  input  logic [NPORTS-1:0]    tx_mask_req,
  input  logic [SELW-1:0]      rx_sel_req,
  output logic [NPORTS-1:0]    tx_mask_act,
  output logic [SELW-1:0]      rx_sel_act,
  output logic                 rx_pending,
  output logic [32*NPORTS-1:0] tx_frame_cnt
);
  localparam logic [63:0] IDLE_D = 64'h0707070707070707;
  localparam logic [7:0]  IDLE_C = 8'hFF;
  localparam int          NSEL   = 1 << SELW;

  logic              app_start, tx_bnd;
  logic [NPORTS-1:0] mask_eff;

  xgmii_frame_trk u_app_trk (
    .clk(xgmii_clk), .rst(sys_rst), .d(app_txd), .c(app_txc),
    .start(app_start), .bnd(tx_bnd)
  );

  assign mask_eff = tx_bnd ? tx_mask_req : tx_mask_act;

  always_ff @(posedge xgmii_clk or posedge sys_rst)
    if (sys_rst) tx_mask_act <= TX_MASK_INIT;
    else         tx_mask_act <= mask_eff;

  for (genvar i = 0; i < NPORTS; i++) begin : g_tx
    xgmii_tx_lane u_lane (
      .clk(xgmii_clk), .rst(sys_rst),
      .app_txd(app_txd), .app_txc(app_txc), .app_start(app_start), .tx_bnd(tx_bnd),
      .mask_en(mask_eff[i]), .link_up(link_up[i]),
      .txd(port_txd[64*i +: 64]), .txc(port_txc[8*i +: 8]),
      .frame_cnt(tx_frame_cnt[32*i +: 32])
    );
  end

  // RX views padded to the full select range so any select code indexes safely.
  logic [NSEL-1:0][63:0] rxd_x;
  logic [NSEL-1:0][7:0]  rxc_x;
  logic [NSEL-1:0]       bnd_x, lnk_x;
  logic [NPORTS-1:0]     unused_rx_start;

  for (genvar i = 0; i < NSEL; i++) begin : g_rx
    if (i < NPORTS) begin : g_port
      assign rxd_x[i] = port_rxd[64*i +: 64];
      assign rxc_x[i] = port_rxc[8*i +: 8];
      assign lnk_x[i] = link_up[i];
      xgmii_frame_trk u_trk (
        .clk(xgmii_clk), .rst(sys_rst), .d(rxd_x[i]), .c(rxc_x[i]),
        .start(unused_rx_start[i]), .bnd(bnd_x[i])
      );
    end else begin : g_pad
      assign rxd_x[i] = IDLE_D;
      assign rxc_x[i] = IDLE_C;
      assign lnk_x[i] = 1'b0;
      assign bnd_x[i] = 1'b0;
    end
  end

  logic            req_ok, do_sw;
  logic [SELW-1:0] sel_eff;

  always_comb begin
    req_ok  = 32'(rx_sel_req) < NPORTS;
    do_sw   = req_ok && (rx_sel_req != rx_sel_act) && bnd_x[rx_sel_act] && bnd_x[rx_sel_req];
    sel_eff = do_sw ? rx_sel_req : rx_sel_act;
  end

  always_ff @(posedge xgmii_clk or posedge sys_rst)
    if (sys_rst) begin
      rx_sel_act <= '0;
      rx_pending <= 1'b0;
      app_rxd    <= IDLE_D;
      app_rxc    <= IDLE_C;
    end else begin
      rx_sel_act <= sel_eff;
      rx_pending <= req_ok && (rx_sel_req != sel_eff);
      app_rxd    <= lnk_x[sel_eff] ? rxd_x[sel_eff] : IDLE_D;
      app_rxc    <= lnk_x[sel_eff] ? rxc_x[sel_eff] : IDLE_C;
    end
endmodule

// File: doc/xgmii_port_fanout.md
# xgmii_port_fanout

Parametrised XGMII steering block between the 10GBASE-R network paths and the user application on the `xgmii_clk` (156.25 MHz) domain. It generalises the fixed "one TX stream copied to every PHY, RX from port 0 only" wiring to NPORTS ports. TX fan-out is set by a per-port enable mask and RX source by a port select. Mask and select changes are applied only at XGMII frame boundaries, so no port ever emits or delivers a truncated frame because of a reconfiguration.

## Interface
- NPORTS, 4, number of XGMII ports (1..8).
- SELW, $clog2(NPORTS) (min 1), width of RX select.
- TX_MASK_INIT, {NPORTS{1'b1}}, TX enable mask after reset.
- xgmii_clk  in  1  sole clock; all logic is on its rising edge.
- sys_rst  in  1  asynchronous, active-high reset.
- app_txd / app_txc  in  64 / 8  application TX stream.
- app_rxd / app_rxc  out  64 / 8  selected RX stream to the application.
- port_txd / port_txc  out  64*NPORTS / 8*NPORTS  per-port TX; port i occupies slice [64i+63:64i] / [8i+7:8i].
- port_rxd / port_rxc  in  64*NPORTS / 8*NPORTS  per-port RX, same slicing.
- link_up  in  NPORTS  per-port block-lock (xphy_status[0]).
- tx_mask_req  in  NPORTS  requested TX enable mask, level.
- rx_sel_req  in  SELW  requested RX port, level.
- tx_mask_act  out  NPORTS  mask currently applied.
- rx_sel_act  out  SELW  RX port currently applied.
- rx_pending  out  1  rx_sel_req != rx_sel_act and the switch has not yet occurred.
- tx_frame_cnt  out  32*NPORTS  per-port count of forwarded TX starts (see Configuration).

## Operation
- IDLE word: data 64'h0707070707070707, ctrl 8'hFF.
- START: lane 0 (txc[0]=1, d[7:0]=8'hFB) or lane 4 (txc[4]=1, d[39:32]=8'hFB). TERMINATE: any lane k with txc[k]=1 and byte 8'hFD.
- Each tracked stream (app TX, every port RX) has an in_frame flag. It is set by a word containing START, cleared by a word containing TERMINATE. If both occur in the same word, the later lane wins.
- Boundary word: in_frame=0 entering the cycle and the word contains no START.
- TX: tx_mask_act <= tx_mask_req on any app TX boundary word. The update takes effect for that same word's output.
  - Port i output = app word if tx_mask_act[i] & link_up[i], else IDLE.
- link_up deassertion forces IDLE immediately, even mid-frame. On reassertion, port i resumes only from the next app boundary word. A per-port resume flag is cleared on link loss and set at the boundary.
- RX: switch rx_sel_act <= rx_sel_req only on a cycle where the word from the old port and the word from the requested port are both boundary words. The switched cycle outputs the new port's word.
  - rx_sel_req values >= NPORTS are ignored; act is held and rx_pending=0.
- app_rx output = selected port word if link_up[sel], else IDLE.

## Timing
- All data outputs are registered; latency from input word to output is exactly 1 cycle, TX and RX.
- tx_mask_act, rx_sel_act and rx_pending are registered. They update in the cycle the switch is applied, so they are visible together with the first output word that uses them.
- Reset values:
  - every port_txd/txc and app_rxd/rxc = IDLE;
  - tx_mask_act = TX_MASK_INIT; rx_sel_act = 0; rx_pending = 0;
  - all in_frame = 0; resume flags = 1; tx_frame_cnt = 0.
- Reset asserted mid-frame: outputs go to IDLE asynchronously. Frame state is discarded, and after release the first word is treated as non-frame.
- A request changed again before it is applied: the latest request value is the one applied.

## Configuration
- XGMII_FANOUT_CNT_EN defined: tx_frame_cnt[i] increments by 1 for each START word actually driven on port i, wrapping from 32'hFFFFFFFF to 0.
- XGMII_FANOUT_CNT_EN undefined: no counter logic; tx_frame_cnt is tied to 0. The ports remain so the interface is unchanged.

## Test plan
- Mask change mid-frame: 8-word frame on app TX, tx_mask_req 4'hF->4'h1 at word 3 -> all ports carry the full frame; tx_mask_act = 4'h1 from the first IDLE after TERMINATE; ports 1-3 IDLE afterwards.
- RX switch: rx_sel_req 0->2 while port 0 mid-frame and port 2 idle -> rx_pending=1 until port 0 terminates; the next cycle where both are at a boundary has rx_sel_act=2 with no truncated frame on app_rx.
- Link drop: link_up[1]=0 at word 4 of a frame -> port 1 is IDLE from the next cycle. Reassert mid-frame -> port 1 stays IDLE until the next app boundary, then carries the following frame complete.
- Latency/reset: single START word at cycle n -> appears on enabled ports at n+1. Assert sys_rst mid-frame -> all outputs IDLE without a clock edge; tx_mask_act=TX_MASK_INIT.
- Counters (macro defined): 5 frames with mask 4'b0101 -> tx_frame_cnt = {0,5,0,5}. Preload via force to 32'hFFFFFFFF, send 1 frame -> 0. Macro undefined -> all counts 0.
- Invalid select with NPORTS=3: rx_sel_req=3 -> rx_sel_act unchanged, rx_pending=0.
